// File: rtl/blackparrot_fpga_host_io_out_buffer.sv
// rtl/blackparrot_fpga_host_io_out_buffer.sv - packs IO chars into CSR words and buffers them for host reads
// Optional: BLACKPARROT_FPGA_HOST_IO_DROP_ON_FULL_EN drops chars on overflow instead of backpressuring.
module blackparrot_fpga_host_io_out_buffer #(
  parameter int S_AXIL_DATA_WIDTH = 32,
  parameter int IO_DATA_WIDTH     = 8,
  parameter int BUF_ELS_P         = 64,
  parameter int FLUSH_CYCLES_P    = 1024
) (
  input  logic                           s_axil_aclk,
  input  logic                           s_axil_aresetn,
  input  logic                           io_v_i,
  output logic                           io_ready_and_o,
  input  logic [IO_DATA_WIDTH-1:0]       io_data_i,
  output logic [1:0]                     fifo_v_o,
  input  logic [1:0]                     fifo_yumi_i,
  output logic [2*S_AXIL_DATA_WIDTH-1:0] fifo_data_o
);
  localparam int PACK_ELS = S_AXIL_DATA_WIDTH / IO_DATA_WIDTH;
  localparam int LW = $clog2(PACK_ELS + 1);
  localparam int AW = $clog2(BUF_ELS_P);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(FLUSH_CYCLES_P) + 1;
  localparam logic [LW-1:0] LANE_FULL = LW'(PACK_ELS);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] OCC_FULL  = PW'(BUF_ELS_P);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_CYCLES_P - 1);

  logic                                     r_live;
  logic [PACK_ELS-1:0][IO_DATA_WIDTH-1:0]   r_pack;
  logic [LW-1:0]                            r_lane_cnt;
  logic [IW-1:0]                            r_idle;
  logic [PW-1:0]                            r_head;
  logic [PW-1:0]                            r_tail;
  logic [S_AXIL_DATA_WIDTH-1:0]             r_mem [BUF_ELS_P];

  logic                         w_pack_full;
  logic                         w_buf_full;
  logic                         w_buf_empty;
  logic                         w_flush_to;
  logic                         w_drain;
  logic                         w_accept;
  logic                         w_pop;
  logic [PW-1:0]                w_occ;
  logic [S_AXIL_DATA_WIDTH-1:0] w_data0;
  logic [S_AXIL_DATA_WIDTH-1:0] w_status;
  logic                         w_unused_yumi1;

  // Fullness uses registered pointers only, so a pop frees space for the next cycle's drain.
  assign w_pack_full    = (r_lane_cnt == LANE_FULL);
  assign w_occ          = r_tail - r_head;
  assign w_buf_full     = (w_occ == OCC_FULL);
  assign w_buf_empty    = (r_head == r_tail);
  assign w_flush_to     = (r_lane_cnt != '0) && (r_idle == IDLE_LAST);
  assign w_drain        = (w_pack_full | w_flush_to) & ~w_buf_full;
  assign w_accept       = r_live & io_v_i & (~w_pack_full | w_drain);
  assign w_pop          = r_live & fifo_yumi_i[0] & ~w_buf_empty;
  assign w_unused_yumi1 = fifo_yumi_i[1];

`ifdef BLACKPARROT_FPGA_HOST_IO_DROP_ON_FULL_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  assign w_drop         = r_live & io_v_i & w_pack_full & ~w_drain;
  assign io_ready_and_o = r_live;

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hff)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`else
  assign io_ready_and_o = r_live & (~w_pack_full | w_drain);
`endif

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      r_live     <= 1'b0;
      r_pack     <= '0;
      r_lane_cnt <= '0;
      r_idle     <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_live <= 1'b1;
      // A char accepted alongside a drain starts the fresh word in lane 0.
      if (w_drain) begin
        r_pack     <= '0;
        r_lane_cnt <= '0;
        if (w_accept) begin
          r_pack[0]  <= io_data_i;
          r_lane_cnt <= LANE_ONE;
        end
      end else if (w_accept) begin
        for (int i = 0; i < PACK_ELS; i++) begin
          if (i == int'(r_lane_cnt)) r_pack[i] <= io_data_i;
        end
        r_lane_cnt <= r_lane_cnt + LANE_ONE;
      end
      if (w_accept | w_drain) begin
        r_idle <= '0;
      end else if ((r_lane_cnt != '0) && !w_flush_to) begin
        r_idle <= r_idle + IDLE_ONE;
      end
      if (w_drain) r_tail <= r_tail + PTR_ONE;
      if (w_pop)   r_head <= r_head + PTR_ONE;
    end
  end

  always_ff @(posedge s_axil_aclk) begin
    if (w_drain) r_mem[r_tail[AW-1:0]] <= r_pack;
  end

  always_comb begin
    w_data0 = w_buf_empty ? '0 : r_mem[r_head[AW-1:0]];
    w_status        = '0;
    w_status[15:0]  = 16'(w_occ);
    w_status[23:16] = 8'(r_lane_cnt);
`ifdef BLACKPARROT_FPGA_HOST_IO_DROP_ON_FULL_EN
    w_status[31:24] = r_drop_cnt;
`endif
  end

  assign fifo_v_o    = {2{r_live}};
  assign fifo_data_o = {w_status, w_data0};
endmodule

// File: tb/tb_blackparrot_fpga_host_io_out_buffer.sv
// tb/tb_blackparrot_fpga_host_io_out_buffer.sv - randomized bench with queue-level reference model
`timescale 1ns/1ps
module tb_blackparrot_fpga_host_io_out_buffer;
  localparam int BUF   = 64;
  localparam int FLUSH = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic        io_v;
  logic        io_ready;
  logic [7:0]  io_data;
  logic [1:0]  fifo_v;
  logic [1:0]  fifo_yumi;
  logic [63:0] fifo_data;

  always #5 clk = ~clk;

  blackparrot_fpga_host_io_out_buffer #(
    .S_AXIL_DATA_WIDTH(32),
    .IO_DATA_WIDTH(8),
    .BUF_ELS_P(BUF),
    .FLUSH_CYCLES_P(FLUSH)
  ) dut (
    .s_axil_aclk(clk),
    .s_axil_aresetn(rstn),
    .io_v_i(io_v),
    .io_ready_and_o(io_ready),
    .io_data_i(io_data),
    .fifo_v_o(fifo_v),
    .fifo_yumi_i(fifo_yumi),
    .fifo_data_o(fifo_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: chars waiting to be packed, and words waiting for the host.
  logic [7:0]  m_pack[$];
  logic [31:0] m_buf[$];
  int          m_idle;
  int          m_drops;

  function automatic bit m_flush();
    return (m_pack.size() != 0) && (m_idle == FLUSH - 1);
  endfunction

  function automatic bit m_drain();
    return ((m_pack.size() == 4) || m_flush()) && (m_buf.size() < BUF);
  endfunction

  function automatic bit m_ready();
`ifdef BLACKPARROT_FPGA_HOST_IO_DROP_ON_FULL_EN
    return 1'b1;
`else
    return (m_pack.size() < 4) || m_drain();
`endif
  endfunction

  function automatic logic [31:0] m_word();
    logic [31:0] w = 32'h0;
    foreach (m_pack[i]) w[8*i +: 8] = m_pack[i];
    return w;
  endfunction

  function automatic logic [31:0] m_status();
    return {8'(m_drops), 8'(m_pack.size()), 16'(m_buf.size())};
  endfunction

  task automatic check_all();
    check_val("valid", 32'(fifo_v), 32'h3);
    check_val("ready", 32'(io_ready), 32'(m_ready()));
    check_val("ch0", fifo_data[31:0], (m_buf.size() != 0) ? m_buf[0] : 32'h0);
    check_val("ch1", fifo_data[63:32], m_status());
  endtask

  // One clock: compare current outputs, apply inputs, advance the model, cross the edge.
  task automatic step(input bit v, input logic [7:0] d, input logic [1:0] y, output bit acc);
    bit dr;
    bit fl;
    int pre_sz;
    check_all();
    io_v      = v;
    io_data   = d;
    fifo_yumi = y;
    dr     = m_drain();
    fl     = m_flush();
    pre_sz = m_pack.size();
    acc    = v && ((pre_sz < 4) || dr);
`ifdef BLACKPARROT_FPGA_HOST_IO_DROP_ON_FULL_EN
    if (v && !acc && m_drops < 255) m_drops++;
`endif
    if (y[0] && m_buf.size() > 0) void'(m_buf.pop_front());
    if (dr) begin
      m_buf.push_back(m_word());
      m_pack.delete();
    end
    if (acc) m_pack.push_back(d);
    if (acc || dr) m_idle = 0;
    else if (pre_sz != 0 && !fl) m_idle++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    io_v      = 1'b0;
    io_data   = 8'h0;
    fifo_yumi = 2'b00;
    rstn      = 1'b0;
    #1;
    check_val("rst_valid", 32'(fifo_v), 32'h0);
    check_val("rst_ready", 32'(io_ready), 32'h0);
    check_val("rst_ch0", fifo_data[31:0], 32'h0);
    check_val("rst_ch1", fifo_data[63:32], 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_pack.delete();
    m_buf.delete();
    m_idle  = 0;
    m_drops = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   guard;
    int   max_occ;
    logic [7:0] c;
    rstn = 1'b0;
    do_reset();

    for (int i = 0; i < 10; i++) step(1'b0, 8'h0, 2'b00, acc);
    check_val("idle_valid", 32'(fifo_v), 32'h3);
    check_val("idle_ch0", fifo_data[31:0], 32'h0);
    check_val("idle_ch1", fifo_data[63:32], 32'h0);
    check_val("idle_ready", 32'(io_ready), 32'h1);

    step(1'b1, 8'h41, 2'b00, acc);
    step(1'b1, 8'h42, 2'b00, acc);
    step(1'b1, 8'h43, 2'b00, acc);
    step(1'b1, 8'h44, 2'b00, acc);
    step(1'b0, 8'h00, 2'b00, acc);
    check_val("abcd_ch0", fifo_data[31:0], 32'h44434241);
    check_val("abcd_occ", 32'(fifo_data[47:32]), 32'h1);
    step(1'b0, 8'h00, 2'b01, acc);
    check_val("abcd_pop_occ", 32'(fifo_data[47:32]), 32'h0);
    check_val("abcd_pop_ch0", fifo_data[31:0], 32'h0);

    step(1'b1, 8'h78, 2'b00, acc);
    check_val("flush_lanes1", 32'(fifo_data[55:48]), 32'h1);
    for (int i = 0; i < FLUSH - 1; i++) step(1'b0, 8'h00, 2'b00, acc);
    check_val("flush_early_ch0", fifo_data[31:0], 32'h0);
    check_val("flush_early_lanes", 32'(fifo_data[55:48]), 32'h1);
    step(1'b0, 8'h00, 2'b00, acc);
    check_val("flush_ch0", fifo_data[31:0], 32'h00000078);
    check_val("flush_lanes0", 32'(fifo_data[55:48]), 32'h0);
    step(1'b0, 8'h00, 2'b01, acc);

    c = 8'h01;
    guard = 0;
    while (!(m_buf.size() == BUF && m_pack.size() == 4) && guard < 2000) begin
      step(1'b1, c, 2'b00, acc);
      if (acc) c = c + 8'h01;
      guard++;
    end
    check_val("fill_bound", 32'(guard < 2000), 32'h1);
    check_val("full_occ", 32'(fifo_data[47:32]), BUF);
`ifdef BLACKPARROT_FPGA_HOST_IO_DROP_ON_FULL_EN
    check_val("full_ready", 32'(io_ready), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h7a, 2'b00, acc);
    check_val("drop_cnt", 32'(fifo_data[63:56]), 32'h5);
    check_val("drop_ready", 32'(io_ready), 32'h1);
`else
    check_val("full_ready", 32'(io_ready), 32'h0);
`endif
    step(1'b0, 8'h00, 2'b01, acc);
    step(1'b0, 8'h00, 2'b00, acc);
    check_val("refill_occ", 32'(fifo_data[47:32]), BUF);
    check_val("refill_ready", 32'(io_ready), 32'h1);
    guard = 0;
    while (m_buf.size() != 0 && guard < 200) begin
      step(1'b0, 8'h00, 2'b01, acc);
      guard++;
    end
    check_val("drain_bound", 32'(guard < 200), 32'h1);

    max_occ = 0;
    for (int i = 0; i < 600; i++) begin
      if (int'(fifo_data[47:32]) > max_occ) max_occ = int'(fifo_data[47:32]);
      step(1'b1, 8'($urandom), 2'b01, acc);
    end
    check_val("stream_max_occ", 32'(max_occ <= 2), 32'h1);

    for (int b = 0; b < 20; b++) begin
      int pv = $urandom_range(0, 4);
      int py = $urandom_range(0, 4);
      for (int i = 0; i < 150; i++) begin
        bit v = ($urandom_range(0, 3) < pv);
        logic [1:0] y = {1'($urandom), ($urandom_range(0, 3) < py)};
        step(v, 8'($urandom), y, acc);
      end
    end

    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 2'b00, acc);
    do_reset();
    for (int i = 0; i < 40; i++) step(1'($urandom), 8'($urandom), 2'($urandom), acc);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
